br_lite_local_injector: RTL and testbench

- Shares a BrLite router's single LOCAL input port among NREQ on-PE requesters (kernel, monitor, DMA, ...), using round-robin arbitration.
- Stamps each accepted flit with this PE's seq_source and a fresh id, then performs the router's req/ack handshake.
- Withholds new injections while the router reports local_busy_o, i.e. while its auto-clear of the previous local flit is outstanding.
- Sits between PE logic and router port BR_LOCAL (flit_i/req_i/ack_o[BR_LOCAL], local_busy_o).

---
 rtl/br_lite_local_injector_pkg.sv | 40 ++++
 rtl/br_lite_rr_arbiter.sv | 37 +++
 rtl/br_lite_local_injector.sv | 99 +++++++++
 tb/tb_br_lite_local_injector.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/br_lite_local_injector_pkg.sv
// BrLite shared types: flit layout, router port and service encodings,
// plus the local injector's id width and FSM state type.
package br_lite_local_injector_pkg;

    typedef enum logic [2:0] {
        BR_EAST  = 3'd0,
        BR_WEST  = 3'd1,
        BR_NORTH = 3'd2,
        BR_SOUTH = 3'd3,
        BR_LOCAL = 3'd4
    } br_port_t;

    typedef enum logic [1:0] {
        BR_SVC_ALL   = 2'd0,
        BR_SVC_TGT   = 2'd1,
        BR_SVC_CLEAR = 2'd2,
        BR_SVC_RSVD  = 2'd3
    } br_service_t;

    typedef logic [3:0] br_id_t;

    typedef struct packed {
        br_service_t service;
        br_id_t      id;
        logic [15:0] seq_source;
        logic [15:0] seq_target;
        logic [31:0] payload;
    } br_data_t;

    localparam int BR_ID_WIDTH = $bits(br_id_t);

    typedef enum logic [2:0] {
        INJ_IDLE    = 3'd0,
        INJ_SEND    = 3'd1,
        INJ_ACK_SRC = 3'd2,
        INJ_HOLD    = 3'd3,
        INJ_REJECT  = 3'd4
    } br_inj_state_t;

endpackage

// File: rtl/br_lite_rr_arbiter.sv
// Round-robin arbiter: search starts one past the last grant and wraps;
// the pointer only moves when a grant is actually taken (enable).
module br_lite_rr_arbiter #(
    parameter int N = 3,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [N-1:0]  req,
    input  logic          enable,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_vld
);

    logic [IW-1:0] last_grant;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int i = N; i >= 1; i--) begin
            if (req[(int'(last_grant) + i) % N]) begin
                gnt_vld = 1'b1;
                gnt_idx = IW'((int'(last_grant) + i) % N);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_grant <= IW'(N - 1);
        end else if (enable && gnt_vld) begin
            last_grant <= gnt_idx;
        end
    end

endmodule

// File: rtl/br_lite_local_injector.sv
// Shares the router LOCAL input among NREQ PE requesters: arbitrates,
// stamps seq_source/id, runs the req/ack handshake and acks the requester.
module br_lite_local_injector
    import br_lite_local_injector_pkg::*;
#(
    parameter int          NREQ        = 3,
    parameter logic [15:0] SEQ_ADDRESS = 16'h0000,
    localparam int         IW          = $clog2(NREQ)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic     [NREQ-1:0]  src_req_i,
    input  br_data_t [NREQ-1:0]  src_flit_i,
    output logic     [NREQ-1:0]  src_ack_o,
    output logic     [NREQ-1:0]  src_err_o,
    input  logic                 br_busy_i,
    output br_data_t             br_flit_o,
    output logic                 br_req_o,
    input  logic                 br_ack_i,
    output logic     [15:0]      injected_o
);

    br_inj_state_t          state_q;
    logic [IW-1:0]          win_q;
    br_data_t               flit_q;
    logic [BR_ID_WIDTH-1:0] id_ctr;
    logic [15:0]            inj_q;

    logic [IW-1:0] gnt_idx;
    logic          gnt_vld;
    logic          arb_en;
    br_data_t      stamped;

    // Busy is only honoured here; once in SEND the transaction always completes.
    assign arb_en = (state_q == INJ_IDLE) && !br_busy_i;

    br_lite_rr_arbiter #(.N(NREQ)) u_arb (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req     (src_req_i),
        .enable  (arb_en),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    always_comb begin
        stamped            = src_flit_i[gnt_idx];
        stamped.seq_source = SEQ_ADDRESS;
        stamped.id         = id_ctr;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= INJ_IDLE;
            win_q   <= '0;
            flit_q  <= '0;
            id_ctr  <= '0;
            inj_q   <= '0;
        end else begin
            case (state_q)
                INJ_IDLE: begin
                    if (arb_en && gnt_vld) begin
                        win_q <= gnt_idx;
                        if (src_flit_i[gnt_idx].service == BR_SVC_CLEAR) begin
                            state_q <= INJ_REJECT;
                        end else begin
                            flit_q  <= stamped;
                            state_q <= INJ_SEND;
                        end
                    end
                end
                INJ_SEND: begin
                    if (br_ack_i) state_q <= INJ_ACK_SRC;
                end
                INJ_ACK_SRC: begin
                    id_ctr  <= id_ctr + 1'b1;
                    inj_q   <= inj_q + 16'd1;
                    state_q <= INJ_HOLD;
                end
                // One dead cycle lets the router's local_busy_o settle.
                INJ_HOLD:   state_q <= INJ_IDLE;
                INJ_REJECT: state_q <= INJ_IDLE;
                default:    state_q <= INJ_IDLE;
            endcase
        end
    end

    always_comb begin
        src_ack_o = '0;
        src_err_o = '0;
        if (state_q == INJ_ACK_SRC || state_q == INJ_REJECT) src_ack_o[win_q] = 1'b1;
        if (state_q == INJ_REJECT) src_err_o[win_q] = 1'b1;
    end

    assign br_req_o   = (state_q == INJ_SEND);
    assign br_flit_o  = flit_q;
    assign injected_o = inj_q;

endmodule

// File: tb/tb_br_lite_local_injector.sv
// Bench for the local injector: a router responder acks requests after a fixed
// delay and records accepted flits; tasks compare them against an expected queue.
module tb_br_lite_local_injector;
    import br_lite_local_injector_pkg::*;

    localparam int NREQ = 3;

    logic                clk = 1'b0;
    logic                rst_i;
    logic     [NREQ-1:0] src_req_i;
    br_data_t [NREQ-1:0] src_flit_i;
    logic     [NREQ-1:0] src_ack_o;
    logic     [NREQ-1:0] src_err_o;
    logic                br_busy_i;
    br_data_t            br_flit_o;
    logic                br_req_o;
    logic                br_ack_i;
    logic     [15:0]     injected_o;

    br_lite_local_injector #(.NREQ(NREQ), .SEQ_ADDRESS(16'h0005)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .src_req_i  (src_req_i),
        .src_flit_i (src_flit_i),
        .src_ack_o  (src_ack_o),
        .src_err_o  (src_err_o),
        .br_busy_i  (br_busy_i),
        .br_flit_o  (br_flit_o),
        .br_req_o   (br_req_o),
        .br_ack_i   (br_ack_i),
        .injected_o (injected_o)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    br_data_t exp_q[$], obs_q[$];
    int       ack_idx_q[$];
    logic     ack_err_q[$];
    int       rise_cyc = -1, rise_cnt = 0, viol = 0;
    bit       resp_en = 1'b1;
    int       ack_lat = 3;

    // Reference model state
    int     m_last = NREQ - 1;
    br_id_t m_id = '0;
    int     m_inj = 0;

    initial begin : router
        int   cnt;
        logic prev_ack, prev_req;
        cnt = 0; prev_ack = 1'b0; prev_req = 1'b0;
        br_ack_i = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_ack && br_req_o) viol++;
            if (|(src_err_o & ~src_ack_o)) viol++;
            if (br_req_o && !prev_req) begin rise_cyc = cyc; rise_cnt++; end
            prev_req = br_req_o;
            for (int i = 0; i < NREQ; i++)
                if (src_ack_o[i]) begin ack_idx_q.push_back(i); ack_err_q.push_back(src_err_o[i]); end
            if (resp_en && br_req_o && !prev_ack) begin
                if (cnt == ack_lat) begin
                    br_ack_i = 1'b1; obs_q.push_back(br_flit_o); cnt = 0;
                end else begin
                    br_ack_i = 1'b0; cnt++;
                end
            end else begin
                br_ack_i = 1'b0; cnt = 0;
            end
            prev_ack = br_ack_i;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic br_data_t mkf(br_service_t s, logic [31:0] p);
        br_data_t f;
        f.service = s; f.id = '1; f.seq_source = 16'hFFFF; f.seq_target = 16'h0003; f.payload = p;
        return f;
    endfunction

    function automatic br_data_t stamp(br_data_t f, br_id_t id);
        f.seq_source = 16'h0005; f.id = id;
        return f;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic wait_acks(input int n, input int budget, output bit timeout);
        int b = 0;
        timeout = 1'b0;
        while (ack_idx_q.size() < n) begin
            tick(1); b++;
            if (b > budget) begin timeout = 1'b1; break; end
        end
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        rst_i = 1'b1; src_req_i = '0; br_busy_i = 1'b0;
        tick(1);
        rst_i = 1'b0;
        exp_q.delete(); obs_q.delete(); ack_idx_q.delete(); ack_err_q.delete();
        m_last = NREQ - 1; m_id = '0; m_inj = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (br_req_o !== 1'b0) begin errors++; $display("FAIL reset_br_req got=%0b exp=0", br_req_o); end
        checks++; if (src_ack_o !== '0) begin errors++; $display("FAIL reset_src_ack got=%b exp=000", src_ack_o); end
        checks++; if (src_err_o !== '0) begin errors++; $display("FAIL reset_src_err got=%b exp=000", src_err_o); end
        checks++; if (injected_o !== 16'd0) begin errors++; $display("FAIL reset_injected got=%0d exp=0", injected_o); end
        checks++; if (br_flit_o !== '0) begin errors++; $display("FAIL reset_flit got=%h exp=0", br_flit_o); end
    endtask

    task automatic test_single();
        br_data_t f, e, o;
        bit to;
        int t0, idx;
        f = mkf(BR_SVC_ALL, 32'hCAFE);
        src_flit_i[1] = f; src_req_i[1] = 1'b1; t0 = cyc;
        e = stamp(f, m_id); exp_q.push_back(e);
        wait_acks(1, 40, to);
        src_req_i[1] = 1'b0;
        m_id++; m_inj++; m_last = 1;
        checks++; if (to) begin errors++; $display("FAIL single_timeout got=no_ack exp=ack"); end
        checks++; if (rise_cyc !== t0 + 1) begin errors++; $display("FAIL single_latency got=%0d exp=%0d", rise_cyc, t0 + 1); end
        idx = ack_idx_q.size() ? ack_idx_q.pop_front() : -1;
        checks++; if (idx !== 1 || ack_err_q.pop_front() !== 1'b0) begin errors++; $display("FAIL single_ack got_idx=%0d exp=1 err=0", idx); end
        checks++;
        if (obs_q.size() == 0) begin errors++; $display("FAIL single_flit got=none exp=%h", e); end
        else begin
            o = obs_q.pop_front(); void'(exp_q.pop_front());
            if (o !== e) begin errors++; $display("FAIL single_flit got=%h exp=%h", o, e); end
            checks++; if (o.seq_source !== 16'h0005 || o.id !== 4'd0) begin errors++; $display("FAIL single_stamp got_src=%h id=%0d exp=5/0", o.seq_source, o.id); end
        end
        tick(1);
        checks++; if (br_req_o !== 1'b0) begin errors++; $display("FAIL single_req_drop got=%0b exp=0", br_req_o); end
        checks++; if (injected_o !== 16'(m_inj)) begin errors++; $display("FAIL single_injected got=%0d exp=%0d", injected_o, m_inj); end
        checks++; if (viol !== 0) begin errors++; $display("FAIL single_protocol got=%0d exp=0", viol); end
        tick(2);
    endtask

    task automatic test_round_robin();
        int exp_idx[$];
        br_data_t e, o;
        bit to;
        int w, idx;
        do_reset();
        for (int i = 0; i < NREQ; i++) src_flit_i[i] = mkf(BR_SVC_TGT, 32'h100 + i);
        src_req_i = '1;
        for (int k = 0; k < 4; k++) begin
            w = (m_last + 1) % NREQ;
            exp_idx.push_back(w); exp_q.push_back(stamp(src_flit_i[w], m_id));
            m_last = w; m_id++; m_inj++;
        end
        wait_acks(4, 200, to);
        src_req_i = '0;
        checks++; if (to) begin errors++; $display("FAIL rr_timeout got=%0d acks exp=4", ack_idx_q.size()); end
        for (int k = 0; k < 4; k++) begin
            idx = ack_idx_q.size() ? ack_idx_q.pop_front() : -1;
            if (ack_err_q.size()) void'(ack_err_q.pop_front());
            checks++; if (idx !== exp_idx[k]) begin errors++; $display("FAIL rr_order[%0d] got=%0d exp=%0d", k, idx, exp_idx[k]); end
            e = exp_q.pop_front();
            o = obs_q.size() ? obs_q.pop_front() : '0;
            checks++; if (o !== e) begin errors++; $display("FAIL rr_flit[%0d] got=%h exp=%h", k, o, e); end
        end
        tick(2);
        checks++; if (injected_o !== 16'(m_inj)) begin errors++; $display("FAIL rr_injected got=%0d exp=%0d", injected_o, m_inj); end
    endtask

    task automatic test_busy();
        br_data_t f, e, o;
        bit to;
        int rc, t0, idx;
        br_busy_i = 1'b1; rc = rise_cnt;
        f = mkf(BR_SVC_ALL, 32'hB05E);
        src_flit_i[0] = f; src_req_i[0] = 1'b1;
        tick(50);
        checks++; if (rise_cnt !== rc) begin errors++; $display("FAIL busy_hold got=%0d rises exp=0", rise_cnt - rc); end
        br_busy_i = 1'b0; t0 = cyc;
        e = stamp(f, m_id); exp_q.push_back(e);
        wait_acks(1, 40, to);
        src_req_i[0] = 1'b0;
        m_id++; m_inj++; m_last = 0;
        checks++; if (to || rise_cyc !== t0 + 1) begin errors++; $display("FAIL busy_release got=%0d exp=%0d", rise_cyc, t0 + 1); end
        idx = ack_idx_q.size() ? ack_idx_q.pop_front() : -1;
        if (ack_err_q.size()) void'(ack_err_q.pop_front());
        checks++; if (idx !== 0) begin errors++; $display("FAIL busy_ack got=%0d exp=0", idx); end
        o = obs_q.size() ? obs_q.pop_front() : '0; void'(exp_q.pop_front());
        checks++; if (o !== e) begin errors++; $display("FAIL busy_flit got=%h exp=%h", o, e); end
        tick(3);
    endtask

    task automatic test_reject();
        br_data_t f, e, o;
        bit to;
        int rc, idx;
        logic err;
        rc = rise_cnt;
        src_flit_i[2] = mkf(BR_SVC_CLEAR, 32'hDEAD); src_req_i[2] = 1'b1;
        wait_acks(1, 20, to);
        src_req_i[2] = 1'b0; m_last = 2;
        idx = ack_idx_q.size() ? ack_idx_q.pop_front() : -1;
        err = ack_err_q.size() ? ack_err_q.pop_front() : 1'b0;
        checks++; if (to || idx !== 2 || err !== 1'b1) begin errors++; $display("FAIL reject_ack got_idx=%0d err=%0b exp=2/1", idx, err); end
        tick(2);
        checks++; if (rise_cnt !== rc) begin errors++; $display("FAIL reject_no_req got=%0d rises exp=0", rise_cnt - rc); end
        checks++; if (injected_o !== 16'(m_inj)) begin errors++; $display("FAIL reject_injected got=%0d exp=%0d", injected_o, m_inj); end
        f = mkf(BR_SVC_ALL, 32'h600D);
        src_flit_i[0] = f; src_req_i[0] = 1'b1;
        e = stamp(f, m_id); exp_q.push_back(e);
        wait_acks(1, 40, to);
        src_req_i[0] = 1'b0;
        m_id++; m_inj++; m_last = 0;
        void'(ack_idx_q.pop_front()); void'(ack_err_q.pop_front());
        o = obs_q.size() ? obs_q.pop_front() : '0; void'(exp_q.pop_front());
        checks++; if (to || o !== e) begin errors++; $display("FAIL reject_next_id got=%h exp=%h", o, e); end
        tick(3);
    endtask

    task automatic test_id_wrap();
        br_data_t f, e, o;
        bit to;
        for (int k = 0; k < 17; k++) begin
            f = mkf(BR_SVC_TGT, 32'h7000 + k);
            src_flit_i[1] = f; src_req_i[1] = 1'b1;
            e = stamp(f, m_id); exp_q.push_back(e);
            wait_acks(1, 40, to);
            src_req_i[1] = 1'b0;
            m_id++; m_inj++; m_last = 1;
            if (ack_idx_q.size()) begin void'(ack_idx_q.pop_front()); void'(ack_err_q.pop_front()); end
            o = obs_q.size() ? obs_q.pop_front() : '0; void'(exp_q.pop_front());
            checks++; if (to || o !== e) begin errors++; $display("FAIL wrap_flit[%0d] got=%h exp=%h", k, o, e); end
            tick(2);
        end
        checks++; if (injected_o !== 16'(m_inj)) begin errors++; $display("FAIL wrap_injected got=%0d exp=%0d", injected_o, m_inj); end
    endtask

    task automatic test_reset_mid();
        br_data_t f, e, o;
        bit to;
        int b;
        resp_en = 1'b0;
        src_flit_i[0] = mkf(BR_SVC_ALL, 32'hABCD); src_req_i[0] = 1'b1;
        b = 0;
        while (!br_req_o && b < 10) begin tick(1); b++; end
        checks++; if (br_req_o !== 1'b1) begin errors++; $display("FAIL mid_send got=%0b exp=1", br_req_o); end
        rst_i = 1'b1;
        tick(1);
        rst_i = 1'b0; src_req_i = '0;
        checks++; if (br_req_o !== 1'b0 || src_ack_o !== '0) begin errors++; $display("FAIL mid_reset got_req=%0b ack=%b exp=0/000", br_req_o, src_ack_o); end
        checks++; if (injected_o !== 16'd0) begin errors++; $display("FAIL mid_injected got=%0d exp=0", injected_o); end
        checks++; if (ack_idx_q.size() !== 0) begin errors++; $display("FAIL mid_spurious_ack got=%0d exp=0", ack_idx_q.size()); end
        exp_q.delete(); obs_q.delete(); ack_idx_q.delete(); ack_err_q.delete();
        m_last = NREQ - 1; m_id = '0; m_inj = 0;
        resp_en = 1'b1;
        tick(1);
        f = mkf(BR_SVC_ALL, 32'h1234);
        src_flit_i[2] = f; src_req_i[2] = 1'b1;
        e = stamp(f, m_id); exp_q.push_back(e);
        wait_acks(1, 40, to);
        src_req_i[2] = 1'b0;
        m_inj++;
        o = obs_q.size() ? obs_q.pop_front() : '0;
        checks++; if (to || o !== e) begin errors++; $display("FAIL mid_fresh got=%h exp=%h", o, e); end
        tick(2);
        checks++; if (injected_o !== 16'(m_inj)) begin errors++; $display("FAIL mid_fresh_injected got=%0d exp=%0d", injected_o, m_inj); end
        checks++; if (viol !== 0) begin errors++; $display("FAIL protocol_total got=%0d exp=0", viol); end
    endtask

    initial begin
        rst_i = 1'b1; src_req_i = '0; src_flit_i = '0; br_busy_i = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_busy();
        test_reject();
        test_id_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
